// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receiver.
//   dataframe_t : one received data byte
//   rx_state_t  : receiver FSM states
//   par_calc    : expected parity bit for a byte (typ 0 = even, 1 = odd)
package uart_rx_pkg;

    localparam int unsigned FrameWidth = 8;

    typedef logic [FrameWidth-1:0] dataframe_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHi
    } rx_state_t;

    // Even parity makes the total count of ones even; odd inverts that.
    function automatic logic par_calc(input dataframe_t data, input logic typ);
        return ^{typ, data};
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing front end of the UART receiver.
//   clk_i      : oversampled UART clock
//   rst_i      : synchronous active-high reset
//   rx_i       : raw asynchronous serial line
//   prescale_i : clocks per bit (8, 16 or 32)
//   cnt_en_i   : run the edge counter (FSM is inside a frame)
//   rx_s_o     : synchronized serial line
//   bit_val_o  : majority of the three mid-bit samples (valid with bit_done_o)
//   bit_done_o : decision strobe at edge_cnt = P/2+1
//   bit_wrap_o : last clock of the current bit (edge_cnt = P-1)
module uart_rx_sampler #(
    parameter int unsigned PRE_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic [PRE_W-1:0] prescale_i,
    input  logic             cnt_en_i,
    output logic             rx_s_o,
    output logic             bit_val_o,
    output logic             bit_done_o,
    output logic             bit_wrap_o
);

    logic             sync_q;
    logic             rx_s_q;
    logic [PRE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             smp0_q, smp1_q;
    logic [PRE_W-1:0] half;

    assign half = prescale_i >> 1;

    // The counter sits at 0 whenever the FSM is outside a frame, so entry to
    // START always begins the start bit at edge_cnt = 0.
    always_comb begin
        edge_cnt_d = '0;
        if (cnt_en_i && !bit_wrap_o) begin
            edge_cnt_d = edge_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            edge_cnt_q <= '0;
            smp0_q     <= 1'b0;
            smp1_q     <= 1'b0;
        end else begin
            sync_q     <= rx_i;
            rx_s_q     <= sync_q;
            edge_cnt_q <= edge_cnt_d;
            if (cnt_en_i && (edge_cnt_q == half - PRE_W'(1))) begin
                smp0_q <= rx_s_q;
            end
            if (cnt_en_i && (edge_cnt_q == half)) begin
                smp1_q <= rx_s_q;
            end
        end
    end

    assign rx_s_o     = rx_s_q;
    // Third sample is taken live on the decision cycle.
    assign bit_val_o  = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign bit_done_o = cnt_en_i && (edge_cnt_q == half + PRE_W'(1));
    assign bit_wrap_o = cnt_en_i && (edge_cnt_q == prescale_i - PRE_W'(1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, one stop.
//   CLK        : oversampled UART clock (PRESCALE x baud)
//   RST        : synchronous active-high reset
//   RX_IN      : serial line, idles high, asynchronous
//   PRESCALE   : clocks per bit (8, 16, 32)
//   PAR_EN     : parity bit present
//   PAR_TYP    : 0 even, 1 odd
//   P_DATA     : last good byte, held until the next good frame
//   DATA_VALID : 1-cycle pulse, P_DATA just updated
//   PAR_ERR    : 1-cycle pulse, parity mismatch, frame dropped
//   STP_ERR    : 1-cycle pulse, stop bit low, frame dropped
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRE_W      = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRE_W-1:0]      PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

    rx_state_t             state_q, state_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  valid_q, valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic rx_s;
    logic bit_val;
    logic bit_done;
    logic bit_wrap;
    logic cnt_en;

    assign cnt_en = (state_q != StIdle) && (state_q != StWaitHi);

    uart_rx_sampler #(
        .PRE_W(PRE_W)
    ) u_sampler (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rx_i       (RX_IN),
        .prescale_i (PRESCALE),
        .cnt_en_i   (cnt_en),
        .rx_s_o     (rx_s),
        .bit_val_o  (bit_val),
        .bit_done_o (bit_done),
        .bit_wrap_o (bit_wrap)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A high majority means the falling edge was a glitch.
                if (bit_done && bit_val) begin
                    state_d = StIdle;
                end else if (bit_wrap) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_done) begin
                    shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                end
                if (bit_wrap) begin
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = PAR_EN ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitCntW'(1);
                    end
                end
            end
            StParity: begin
                // Still here at the wrap only if the decision matched.
                if (bit_done && (bit_val != par_calc(dataframe_t'(shift_q), PAR_TYP))) begin
                    par_err_d = 1'b1;
                    state_d   = StWaitHi;
                end else if (bit_wrap) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                if (bit_done) begin
                    if (bit_val) begin
                        valid_d  = 1'b1;
                        p_data_d = shift_q;
                        state_d  = StIdle;
                    end else begin
                        stp_err_d = 1'b1;
                        state_d   = StWaitHi;
                    end
                end
            end
            StWaitHi: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule
